local_inject_scheduler: RTL and testbench
=========================================

// Module: local_inject_scheduler
// PURPOSE
// - Shares one local injection port (the device side credit-flow-control port) among N_REQ local requesters.
// - Grants whole packets (head..tail); RT class (qos=='1) strictly over common class; round-robin within class.
// - Sits between device-side sources and the local port: drives flit_vld_o/flit_qos_value_o, consumes its ready.
// PARAMETERS
// - N_REQ        4                          number of local requesters (>=2)
// - N_REQ_IDX_W  $clog2(N_REQ)              requester index width
// - AGE_THRESH   16                         wait cycles before a common requester is promoted (aging only)
// - AGE_W        $clog2(AGE_THRESH+1)       aging counter width (aging only)
// PORTS
// - clk              in   1                         clock
// - rst              in   1                         synchronous reset, active-high
// - req_vld_i        in   N_REQ                     requester has a flit
// - req_qos_i        in   N_REQ*QoS_Value_Width     requester flit QoS; all-ones = RT
// - req_tail_i       in   N_REQ                     requester flit is tail (single-flit packet: head=tail)
// - req_rdy_o        out  N_REQ                     flit of requester i accepted this cycle
// - flit_vld_o       out  1                         flit valid to local port
// - flit_qos_value_o out  QoS_Value_Width          QoS of selected flit
// - flit_sel_idx_o   out  N_REQ_IDX_W              data-mux select (index of selected requester)
// - flit_rdy_i       in   1                         local port ready (credit available)
// - busy_o           out  1                         state==OWNED
// BEHAVIOUR
// - Clock/reset: one clock; reset synchronous, active-high. Reset: state=IDLE, owner=0, rr_ptr_rt=rr_ptr_com=0, age counters=0.
// - While rst=1: flit_vld_o=0, req_rdy_o=0, busy_o=0, flit_sel_idx_o=0, flit_qos_value_o=0.
// - Handshake: flit accepted when flit_vld_o & flit_rdy_i; req_rdy_o[i] = accept & (flit_sel_idx_o==i). 0-cycle latency, no storage.
// - Requester rule: once valid, hold req_vld_i/qos/tail stable until accepted (bench asserts).
// - States: IDLE, OWNED (owner register holds granted index).
// - IDLE: winner combinational: aged set (if enabled) > RT set (vld & qos=='1) > common set; RR within set starting at that set's ptr.
//   flit_vld_o = |req_vld_i; sel = winner; qos = req_qos_i[winner].
//   - accept & tail: stay IDLE, advance ptr of winner's class to (winner+1) mod N_REQ.
//   - accept & ~tail: -> OWNED, owner=winner.
//   - vld & ~flit_rdy_i: -> OWNED, owner=winner (grant frozen; later higher-priority requests must not preempt).
// - OWNED: sel=owner; flit_vld_o = req_vld_i[owner] (mid-packet bubbles allowed, stay OWNED); qos = req_qos_i[owner].
//   - accept & tail: -> IDLE, advance owner's class ptr to (owner+1) mod N_REQ; next winner evaluated next cycle.
// - Class of a packet decided at head; ptr of that class updated, other class ptr unchanged.
// - Wrap: ptr N_REQ-1 advances to 0. Non-power-of-2 N_REQ: ptr never exceeds N_REQ-1.
// - No requests: flit_vld_o=0, state unchanged, ptrs unchanged.
// - Reset mid-packet: returns to IDLE; partial packet dropped by scheduler, no replay.
// CONFIGURATION
// - Macro LOCAL_INJECT_AGING_EN.
// - Defined: per-requester age counter, increments (saturating at AGE_THRESH) each cycle req_vld_i[i] & qos!='1 & not accepted;
//   clears on tail accept of i and on rst. age==AGE_THRESH marks i aged; aged set beats RT set in IDLE arbitration (RR via rr_ptr_com).
// - Not defined: no counters; aged set empty; pure RT-over-common RR.
// TESTING
// - Reset: rst=1 2 cycles with all req_vld_i=1 -> flit_vld_o=0, req_rdy_o=0; after release, sel=0 first.
// - RR: 4 common single-flit reqs, flit_rdy_i=1 -> accepts in order 0,1,2,3,0; ptr wraps 3->0.
// - RT priority: req0 common, req2 qos=='1, both single-flit -> req2 accepted first, then req0; rr_ptr_com unchanged by req2.
// - Packet lock: req1 3-flit packet, req0 RT arrives after head accepted -> req1 flits 2,3 accepted before req0; bubble on req1 keeps busy_o=1.
// - Credit stall: flit_rdy_i=0 with req3 pending, then RT req1 arrives -> sel stays 3 until flit_rdy_i=1; req3 accepted first.
// - Aging (LOCAL_INJECT_AGING_EN, AGE_THRESH=4): req0 common vs continuous RT req1 -> req0 accepted within 5 grants of req1; without macro req0 starves.

Source files
------------

// File: rtl/local_inject_scheduler_if.sv
// rtl/local_inject_scheduler_if.sv - requester/local-port signal bundle for the local injection scheduler
interface local_inject_scheduler_if #(
  parameter int N_REQ           = 4,
  parameter int N_REQ_IDX_W     = $clog2(N_REQ),
  parameter int QOS_VALUE_WIDTH = 4
);
  logic [N_REQ-1:0]                 req_vld_i;
  logic [N_REQ*QOS_VALUE_WIDTH-1:0] req_qos_i;
  logic [N_REQ-1:0]                 req_tail_i;
  logic [N_REQ-1:0]                 req_rdy_o;
  logic                             flit_vld_o;
  logic [QOS_VALUE_WIDTH-1:0]       flit_qos_value_o;
  logic [N_REQ_IDX_W-1:0]           flit_sel_idx_o;
  logic                             flit_rdy_i;
  logic                             busy_o;

  modport master (
    input  req_vld_i, req_qos_i, req_tail_i, flit_rdy_i,
    output req_rdy_o, flit_vld_o, flit_qos_value_o, flit_sel_idx_o, busy_o
  );

  modport slave (
    output req_vld_i, req_qos_i, req_tail_i, flit_rdy_i,
    input  req_rdy_o, flit_vld_o, flit_qos_value_o, flit_sel_idx_o, busy_o
  );
endinterface

// File: rtl/local_inject_scheduler.sv
// rtl/local_inject_scheduler.sv - packet-granular RT-over-common round-robin scheduler for the local injection port
// Optional aging of starved common requesters is enabled by LOCAL_INJECT_AGING_EN.
module local_inject_scheduler #(
  parameter int N_REQ           = 4,
  parameter int N_REQ_IDX_W     = $clog2(N_REQ),
  parameter int QOS_VALUE_WIDTH = 4,
  parameter int AGE_THRESH      = 16,
  parameter int AGE_W           = $clog2(AGE_THRESH + 1)
) (
  input  logic                      clk,
  input  logic                      rst,
  local_inject_scheduler_if.master  bus
);

  typedef enum logic {IDLE, OWNED} state_t;

  state_t                   state;
  logic [N_REQ_IDX_W-1:0]   owner;
  logic                     owner_rt;
  logic [N_REQ_IDX_W-1:0]   rr_ptr_rt;
  logic [N_REQ_IDX_W-1:0]   rr_ptr_com;

  logic [QOS_VALUE_WIDTH-1:0] qos_arr [N_REQ];
  logic [N_REQ-1:0]           rt_set;
  logic [N_REQ-1:0]           com_set;
  logic [N_REQ-1:0]           aged_set;
  logic [N_REQ_IDX_W-1:0]     win;
  logic                       win_rt;
  logic [N_REQ_IDX_W-1:0]     sel;
  logic                       accept;
  logic                       tail_sel;

  // First member of cand at or after ptr, scanning cyclically.
  function automatic logic [N_REQ_IDX_W-1:0] rr_pick(input logic [N_REQ-1:0] cand,
                                                     input logic [N_REQ_IDX_W-1:0] ptr);
    logic [N_REQ_IDX_W-1:0] pick;
    logic [N_REQ_IDX_W:0]   sum;
    logic [N_REQ_IDX_W-1:0] idx;
    logic                   found;
    pick  = '0;
    found = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      sum = {1'b0, ptr} + (N_REQ_IDX_W+1)'(k);
      if (sum >= (N_REQ_IDX_W+1)'(N_REQ)) begin
        sum = sum - (N_REQ_IDX_W+1)'(N_REQ);
      end
      idx = sum[N_REQ_IDX_W-1:0];
      if (!found && cand[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
    return pick;
  endfunction

  function automatic logic [N_REQ_IDX_W-1:0] adv(input logic [N_REQ_IDX_W-1:0] p);
    return (p == N_REQ_IDX_W'(N_REQ - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      qos_arr[i] = bus.req_qos_i[i*QOS_VALUE_WIDTH +: QOS_VALUE_WIDTH];
      rt_set[i]  = bus.req_vld_i[i] & (&qos_arr[i]);
      com_set[i] = bus.req_vld_i[i] & ~(&qos_arr[i]);
    end
  end

`ifdef LOCAL_INJECT_AGING_EN
  logic [AGE_W-1:0] age [N_REQ];

  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      aged_set[i] = com_set[i] & (age[i] == AGE_W'(AGE_THRESH));
    end
  end

  // Waiting common requesters accumulate age until their packet's tail goes out.
  always_ff @(posedge clk) begin
    for (int i = 0; i < N_REQ; i++) begin
      if (rst) begin
        age[i] <= '0;
      end else if (bus.req_rdy_o[i] && bus.req_tail_i[i]) begin
        age[i] <= '0;
      end else if (com_set[i] && !bus.req_rdy_o[i] && (age[i] != AGE_W'(AGE_THRESH))) begin
        age[i] <= age[i] + 1'b1;
      end
    end
  end
`else
  assign aged_set = '0;
`endif

  always_comb begin
    if (|aged_set) begin
      win    = rr_pick(aged_set, rr_ptr_com);
      win_rt = 1'b0;
    end else if (|rt_set) begin
      win    = rr_pick(rt_set, rr_ptr_rt);
      win_rt = 1'b1;
    end else begin
      win    = rr_pick(com_set, rr_ptr_com);
      win_rt = 1'b0;
    end
  end

  always_comb begin
    sel = (state == OWNED) ? owner : win;
    if (rst) begin
      bus.flit_vld_o       = 1'b0;
      bus.flit_sel_idx_o   = '0;
      bus.flit_qos_value_o = '0;
      bus.busy_o           = 1'b0;
    end else begin
      bus.flit_vld_o       = (state == OWNED) ? bus.req_vld_i[owner] : (|bus.req_vld_i);
      bus.flit_sel_idx_o   = sel;
      bus.flit_qos_value_o = qos_arr[sel];
      bus.busy_o           = (state == OWNED);
    end
    accept   = bus.flit_vld_o & bus.flit_rdy_i;
    tail_sel = bus.req_tail_i[sel];
    for (int i = 0; i < N_REQ; i++) begin
      bus.req_rdy_o[i] = accept & (sel == N_REQ_IDX_W'(i));
    end
  end

  // A head that is not also an accepted tail freezes the grant, even under a credit stall.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      owner      <= '0;
      owner_rt   <= 1'b0;
      rr_ptr_rt  <= '0;
      rr_ptr_com <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|bus.req_vld_i) begin
            if (accept && tail_sel) begin
              if (win_rt) rr_ptr_rt  <= adv(win);
              else        rr_ptr_com <= adv(win);
            end else begin
              state    <= OWNED;
              owner    <= win;
              owner_rt <= win_rt;
            end
          end
        end
        OWNED: begin
          if (accept && tail_sel) begin
            state <= IDLE;
            if (owner_rt) rr_ptr_rt  <= adv(owner);
            else          rr_ptr_com <= adv(owner);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_local_inject_scheduler.sv
// tb/tb_local_inject_scheduler.sv - scoreboard bench for local_inject_scheduler with a packet-level reference model
module tb_local_inject_scheduler;
  localparam int N  = 4;
  localparam int IW = 2;
  localparam int QW = 4;
  localparam int AT = 4;
`ifdef LOCAL_INJECT_AGING_EN
  localparam bit AGING_ON = 1'b1;
`else
  localparam bit AGING_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  local_inject_scheduler_if #(.N_REQ(N), .N_REQ_IDX_W(IW), .QOS_VALUE_WIDTH(QW)) bus ();

  local_inject_scheduler #(
    .N_REQ(N), .N_REQ_IDX_W(IW), .QOS_VALUE_WIDTH(QW), .AGE_THRESH(AT), .AGE_W($clog2(AT + 1))
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  logic [N-1:0]  vld;
  logic [N-1:0]  tail;
  logic [QW-1:0] qos [N];
  logic          rdy;

  always_comb begin
    bus.req_vld_i  = vld;
    bus.req_tail_i = tail;
    bus.flit_rdy_i = rdy;
    for (int i = 0; i < N; i++) bus.req_qos_i[i*QW +: QW] = qos[i];
  end

  typedef struct {int cyc; int idx; int q;} exp_t;
  exp_t expq[$];
  exp_t e;
  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  function automatic void chk(string nm, int act, int exp_v);
    total++;
    if (act !== exp_v) begin
      bad++;
      $display("FAIL %s cyc=%0d actual=%0d required=%0d", nm, cyc, act, exp_v);
    end
  endfunction

  // Reference model: owner-or-none plus a "next in line" pointer per class.
  bit m_owned;
  int m_owner;
  bit m_owner_rt;
  int m_ptr_rt, m_ptr_com;
  int m_age [N];
  bit m_acc;
  int m_acc_idx;
  int rem [N];

  function automatic int rr_choose(logic [N-1:0] s, int p);
    int best, bd;
    best = -1;
    bd   = N;
    for (int i = 0; i < N; i++) begin
      if (s[i] && ((i - p + N) % N) < bd) begin
        bd   = (i - p + N) % N;
        best = i;
      end
    end
    return best;
  endfunction

  task automatic model_reset();
    m_owned = 0; m_owner = 0; m_owner_rt = 0;
    m_ptr_rt = 0; m_ptr_com = 0;
    m_acc = 0; m_acc_idx = -1;
    for (int i = 0; i < N; i++) begin
      m_age[i] = 0;
      rem[i]   = 0;
    end
  endtask

  task automatic model_step();
    logic [N-1:0] rts, coms, ageds;
    int w;
    bit wrt;
    m_acc = 0;
    m_acc_idx = -1;
    for (int i = 0; i < N; i++) begin
      rts[i]   = vld[i] && (qos[i] == {QW{1'b1}});
      coms[i]  = vld[i] && (qos[i] != {QW{1'b1}});
      ageds[i] = AGING_ON && coms[i] && (m_age[i] >= AT);
    end
    if (!m_owned) begin
      if (vld != 0) begin
        if (ageds != 0)    begin w = rr_choose(ageds, m_ptr_com); wrt = 0; end
        else if (rts != 0) begin w = rr_choose(rts, m_ptr_rt);   wrt = 1; end
        else               begin w = rr_choose(coms, m_ptr_com); wrt = 0; end
        if (rdy) begin
          m_acc = 1;
          m_acc_idx = w;
        end
        if (rdy && tail[w]) begin
          if (wrt) m_ptr_rt = (w + 1) % N;
          else     m_ptr_com = (w + 1) % N;
        end else begin
          m_owned = 1; m_owner = w; m_owner_rt = wrt;
        end
      end
    end else if (vld[m_owner] && rdy) begin
      m_acc = 1;
      m_acc_idx = m_owner;
      if (tail[m_owner]) begin
        m_owned = 0;
        if (m_owner_rt) m_ptr_rt = (m_owner + 1) % N;
        else            m_ptr_com = (m_owner + 1) % N;
      end
    end
    if (m_acc) expq.push_back('{cyc, m_acc_idx, int'(qos[m_acc_idx])});
    if (AGING_ON) begin
      for (int i = 0; i < N; i++) begin
        if (m_acc && m_acc_idx == i) begin
          if (tail[i]) m_age[i] = 0;
        end else if (coms[i]) begin
          m_age[i] = (m_age[i] < AT) ? m_age[i] + 1 : AT;
        end
      end
    end
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    vld = '0;
    model_reset();
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // Monitor: every accepted flit must match the oldest predicted acceptance.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (bus.flit_vld_o && rdy) begin
          if (expq.size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected_accept cyc=%0d actual_idx=%0d required=none", cyc, bus.flit_sel_idx_o);
          end else begin
            e = expq.pop_front();
            chk("acc_cycle", cyc, e.cyc);
            chk("acc_idx", int'(bus.flit_sel_idx_o), e.idx);
            chk("acc_qos", int'(bus.flit_qos_value_o), e.q);
            chk("acc_req_rdy", int'(bus.req_rdy_o), 1 << e.idx);
          end
        end
        while (expq.size() > 0 && expq[0].cyc <= cyc) begin
          e = expq.pop_front();
          total++; bad++;
          $display("FAIL missed_accept cyc=%0d actual=none required_idx=%0d", cyc, e.idx);
        end
      end
    end
  end

  int found;

  initial begin
    rst = 1'b1;
    vld = '1;
    tail = '1;
    rdy = 1'b1;
    for (int i = 0; i < N; i++) qos[i] = '0;
    model_reset();

    repeat (2) begin
      @(posedge clk); #1;
      chk("rst_flit_vld", int'(bus.flit_vld_o), 0);
      chk("rst_req_rdy", int'(bus.req_rdy_o), 0);
      chk("rst_busy", int'(bus.busy_o), 0);
      chk("rst_sel", int'(bus.flit_sel_idx_o), 0);
    end
    rst = 1'b0;
    #1;
    chk("post_rst_sel", int'(bus.flit_sel_idx_o), 0);
    vld = '0;
    step();

    // Round robin over four common single-flit requesters, including the wrap.
    vld = '1; tail = '1; rdy = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("rr_order", int'(bus.flit_sel_idx_o), k % 4);
      step();
    end
    vld = '0;
    step();

    // RT beats common; the RT grant leaves the common pointer alone.
    apply_reset();
    qos[0] = '0; qos[2] = '1; qos[3] = '0; tail = '1; rdy = 1'b1;
    vld = 4'b1101;
    #1; chk("rt_first", int'(bus.flit_sel_idx_o), 2);
    step();
    vld = 4'b1001;
    #1; chk("com_ptr_kept", int'(bus.flit_sel_idx_o), 0);
    step();
    vld = 4'b1000;
    #1; chk("com_next", int'(bus.flit_sel_idx_o), 3);
    step();
    vld = '0;
    step();

    // Packet lock with a mid-packet bubble while an RT request waits.
    apply_reset();
    qos[1] = '0; qos[0] = '1; rdy = 1'b1;
    vld = 4'b0010; tail = 4'b0001;
    #1; chk("lock_head", int'(bus.flit_sel_idx_o), 1);
    step();
    vld = 4'b0001;
    #1;
    chk("bubble_vld", int'(bus.flit_vld_o), 0);
    chk("bubble_busy", int'(bus.busy_o), 1);
    step();
    vld = 4'b0011;
    #1; chk("lock_flit2", int'(bus.flit_sel_idx_o), 1);
    step();
    tail[1] = 1'b1;
    #1; chk("lock_flit3", int'(bus.flit_sel_idx_o), 1);
    step();
    vld = 4'b0001;
    #1; chk("lock_rt_after", int'(bus.flit_sel_idx_o), 0);
    step();
    vld = '0;
    step();

    // Credit stall freezes the grant against a later RT request.
    apply_reset();
    rdy = 1'b0; qos[3] = '0; qos[1] = '1; tail = '1;
    vld = 4'b1000;
    step();
    vld = 4'b1010;
    #1; chk("stall_sel_a", int'(bus.flit_sel_idx_o), 3);
    step();
    #1; chk("stall_sel_b", int'(bus.flit_sel_idx_o), 3);
    rdy = 1'b1;
    #1; chk("stall_release", int'(bus.flit_sel_idx_o), 3);
    step();
    vld = 4'b0010;
    #1; chk("stall_rt_next", int'(bus.flit_sel_idx_o), 1);
    step();
    vld = '0;
    step();

    // Common requester against a continuous RT stream.
    apply_reset();
    qos[0] = '0; qos[1] = '1; tail = '1; rdy = 1'b1;
    vld = 4'b0011;
    found = -1;
    for (int k = 0; k < 12; k++) begin
      #1;
      if (found < 0 && bus.flit_vld_o && bus.flit_sel_idx_o == 0) found = k;
      step();
      if (m_acc && m_acc_idx == 0) vld[0] = 1'b0;
    end
    vld = '0;
    step();
`ifdef LOCAL_INJECT_AGING_EN
    chk("aging_bound", int'(found >= 0 && found <= AT + 1), 1);
`else
    chk("common_starves", found, -1);
`endif

    // Randomized multi-flit traffic with bubbles, stalls and a mid-run reset.
    apply_reset();
    for (int c = 0; c < 600; c++) begin
      if (c == 300) apply_reset();
      for (int i = 0; i < N; i++) begin
        if (!(vld[i] && !(m_acc && m_acc_idx == i))) begin
          if (m_acc && m_acc_idx == i) rem[i]--;
          vld[i] = 1'b0;
          if (rem[i] == 0 && $urandom_range(0, 2) == 0) begin
            rem[i] = $urandom_range(1, 3);
            qos[i] = ($urandom_range(0, 3) == 0) ? {QW{1'b1}} : QW'($urandom_range(0, 14));
          end
          if (rem[i] > 0 && $urandom_range(0, 3) != 0) begin
            vld[i]  = 1'b1;
            tail[i] = (rem[i] == 1);
          end
        end
      end
      rdy = ($urandom_range(0, 9) < 7);
      step();
    end
    vld = '0;
    step();
    step();
    chk("queue_drained", expq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
